// File: rtl/bus_decoder.sv
// Address decoder and bus controller between the maxicore32 master and SLAVES peripherals.
// Ports: clock/reset; master address/read/write; per-slave ready and packed read data in;
//        one-hot registered chip selects, gated strobes, registered read data, ready/bus_error pulses,
//        captured fault address and busy flag out.
module bus_decoder #(
  parameter int                  SLAVES       = 4,
  parameter logic [SLAVES*8-1:0] REGION_BASES = {8'h20, 8'h10, 8'h0f, 8'h00},
  parameter logic [SLAVES*4-1:0] WAIT_STATES  = {4'd3, 4'd2, 4'd0, 4'd0},
  parameter int                  TIMEOUT      = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [29:0]          address,
  input  logic                 read,
  input  logic                 write,
  input  logic [SLAVES-1:0]    slave_ready,
  input  logic [SLAVES*32-1:0] slave_data_in,
  output logic [SLAVES-1:0]    slave_cs,
  output logic                 slave_read,
  output logic                 slave_write,
  output logic [31:0]          data_out,
  output logic                 ready,
  output logic                 bus_error,
  output logic [29:0]          error_address,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE, ERROR} state_t;

  state_t              state_q, state_d;
  logic [SLAVES-1:0]   cs_q, cs_d;
  logic [3:0]          wait_q, wait_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic [31:0]         data_q, data_d;
  logic [29:0]         eaddr_q, eaddr_d;

  // Region match: scanning upward and stopping at the first hit makes
  // duplicate bases resolve to the lowest slave index.
  logic                hit;
  logic [SLAVES-1:0]   hit_cs;
  logic [3:0]          hit_wait;

  always_comb begin
    hit      = 1'b0;
    hit_cs   = '0;
    hit_wait = '0;
    for (int i = 0; i < SLAVES; i++) begin
      if (!hit && (address[29:22] == REGION_BASES[i*8 +: 8])) begin
        hit       = 1'b1;
        hit_cs[i] = 1'b1;
        hit_wait  = WAIT_STATES[i*4 +: 4];
      end
    end
  end

  // cs_q is one-hot while in ACCESS, so masking and OR-ing selects the
  // active slave's data and handshake without keeping a separate index.
  logic [31:0] sel_data;
  logic        sel_rdy;

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < SLAVES; i++) begin
      sel_data = sel_data | (slave_data_in[i*32 +: 32] & {32{cs_q[i]}});
    end
    sel_rdy = |(slave_ready & cs_q);
  end

  logic completing;

  always_comb begin
    state_d    = state_q;
    cs_d       = cs_q;
    wait_d     = wait_q;
    tmo_d      = tmo_q;
    data_d     = data_q;
    eaddr_d    = eaddr_q;
    completing = (wait_q == 4'd0) && sel_rdy;

    case (state_q)
      IDLE: begin
        if (read || write) begin
          if ((read && write) || !hit) begin
            state_d = ERROR;
            eaddr_d = address;
          end else begin
            state_d = ACCESS;
            cs_d    = hit_cs;
            wait_d  = hit_wait;
            tmo_d   = '0;
          end
        end
      end
      ACCESS: begin
        if (!read && !write) begin
          // Master abort: silently return, no pulse for this transfer.
          state_d = IDLE;
          cs_d    = '0;
        end else if ((tmo_q == TW'(TIMEOUT - 1)) && !completing) begin
          state_d = ERROR;
          cs_d    = '0;
          eaddr_d = address;
        end else begin
          tmo_d = tmo_q + TW'(1);
          if (wait_q != 4'd0) begin
            wait_d = wait_q - 4'd1;
          end else if (sel_rdy) begin
            state_d = DONE;
            cs_d    = '0;
            if (read) begin
              data_d = sel_data;
            end
          end
        end
      end
      DONE:    state_d = IDLE;
      ERROR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cs_q    <= '0;
      wait_q  <= '0;
      tmo_q   <= '0;
      data_q  <= '0;
      eaddr_q <= '0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      wait_q  <= wait_d;
      tmo_q   <= tmo_d;
      data_q  <= data_d;
      eaddr_q <= eaddr_d;
    end
  end

  assign slave_cs      = cs_q;
  assign slave_read    = read  & (|cs_q);
  assign slave_write   = write & (|cs_q);
  assign data_out      = data_q;
  assign error_address = eaddr_q;
  assign ready         = (state_q == DONE);
  assign bus_error     = (state_q == ERROR);
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_bus_decoder.sv
// Testbench for bus_decoder: directed transfers push expected pulses into a
// scoreboard queue; a negedge monitor pops and checks each ready/bus_error.
module tb_bus_decoder;

  logic         clock = 1'b0;
  logic         reset;
  logic [29:0]  address;
  logic         read;
  logic         write;
  logic [3:0]   slave_ready;
  logic [127:0] slave_data_in;
  logic [3:0]   slave_cs;
  logic         slave_read;
  logic         slave_write;
  logic [31:0]  data_out;
  logic         ready;
  logic         bus_error;
  logic [29:0]  error_address;
  logic         busy;

  bus_decoder dut (
    .clock         (clock),
    .reset         (reset),
    .address       (address),
    .read          (read),
    .write         (write),
    .slave_ready   (slave_ready),
    .slave_data_in (slave_data_in),
    .slave_cs      (slave_cs),
    .slave_read    (slave_read),
    .slave_write   (slave_write),
    .data_out      (data_out),
    .ready         (ready),
    .bus_error     (bus_error),
    .error_address (error_address),
    .busy          (busy)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_mis = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic        is_err;
    int          cyc;
    logic [31:0] data;
    logic [29:0] eaddr;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  // Monitor: every ready/bus_error pulse must match the oldest expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    if (!reset && (ready || bus_error)) begin
      if (sb.size() == 0) begin
        chk("unexpected pulse {bus_error,ready}", {62'b0, bus_error, ready}, 64'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse is bus_error", {63'b0, bus_error}, {63'b0, e.is_err});
        chk("pulse cycle", 64'(cyc), 64'(e.cyc));
        chk("ready and bus_error together", {63'b0, ready && bus_error}, 64'd0);
        if (e.is_err) chk("error_address", {34'b0, error_address}, {34'b0, e.eaddr});
        else          chk("data_out", {32'b0, data_out}, {32'b0, e.data});
      end
    end
  end

  // One master transfer: issue, hold until a pulse, then drop the request.
  task automatic xfer(input string nm, input logic [29:0] a, input logic r, input logic w,
                      input logic is_err, input int lat, input logic [31:0] edata,
                      input logic [3:0] ecs, input int ecs_cnt);
    exp_t e;
    int   cs_cnt = 0;
    logic cs_bad = 1'b0;
    logic strobe_bad = 1'b0;
    logic done = 1'b0;
    @(negedge clock);
    address = a;
    read    = r;
    write   = w;
    e.is_err = is_err;
    e.cyc    = cyc + lat;
    e.data   = edata;
    e.eaddr  = a;
    sb.push_back(e);
    for (int k = 0; k < 64 && !done; k++) begin
      @(negedge clock);
      if (slave_cs != 4'b0) begin
        cs_cnt++;
        if (slave_cs != ecs) cs_bad = 1'b1;
      end
      if (slave_write != (w && (slave_cs != 4'b0))) strobe_bad = 1'b1;
      if (slave_read  != (r && (slave_cs != 4'b0))) strobe_bad = 1'b1;
      if (ready || bus_error) begin
        done  = 1'b1;
        read  = 1'b0;
        write = 1'b0;
      end
    end
    if (!done) begin
      chk({nm, " pulse within budget"}, 64'd0, 64'd1);
      read  = 1'b0;
      write = 1'b0;
    end
    chk({nm, " cs cycles"}, 64'(cs_cnt), 64'(ecs_cnt));
    chk({nm, " cs value bad"}, {63'b0, cs_bad}, 64'd0);
    chk({nm, " strobe gating bad"}, {63'b0, strobe_bad}, 64'd0);
    @(negedge clock);
    chk({nm, " busy after"}, {63'b0, busy}, 64'd0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    address       = '0;
    read          = 1'b0;
    write         = 1'b0;
    slave_ready   = 4'hf;
    slave_data_in = {32'h33333333, 32'hcafef00d, 32'h11111111, 32'hdeadbeef};

    repeat (2) @(negedge clock);
    chk("reset slave_cs",      {60'b0, slave_cs}, 64'd0);
    chk("reset ready",         {63'b0, ready}, 64'd0);
    chk("reset bus_error",     {63'b0, bus_error}, 64'd0);
    chk("reset busy",          {63'b0, busy}, 64'd0);
    chk("reset data_out",      {32'b0, data_out}, 64'd0);
    chk("reset error_address", {34'b0, error_address}, 64'd0);
    reset = 1'b0;

    // Reset in the middle of a slave 3 read after two wait edges.
    @(negedge clock);
    address = 30'h08000000;
    read    = 1'b1;
    repeat (3) @(negedge clock);
    chk("midaccess cs before reset", {60'b0, slave_cs}, 64'b1000);
    chk("midaccess busy before reset", {63'b0, busy}, 64'd1);
    reset = 1'b1;
    #1;
    chk("midaccess cs after reset", {60'b0, slave_cs}, 64'd0);
    chk("midaccess busy after reset", {63'b0, busy}, 64'd0);
    read = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    repeat (6) @(negedge clock);
    chk("midaccess idle later", {63'b0, busy}, 64'd0);

    xfer("read s0",  30'h00000004, 1'b1, 1'b0, 1'b0, 2,  32'hdeadbeef, 4'b0001, 1);
    xfer("write s2", 30'h04000001, 1'b0, 1'b1, 1'b0, 4,  32'hdeadbeef, 4'b0100, 3);

    slave_ready = 4'b1101;
    xfer("timeout s1", 30'h03c00000, 1'b1, 1'b0, 1'b1, 17, 32'h0, 4'b0010, 16);
    slave_ready = 4'hf;

    xfer("unmapped",   30'h10000000, 1'b1, 1'b0, 1'b1, 1, 32'h0, 4'b0000, 0);
    xfer("read+write", 30'h00000000, 1'b1, 1'b1, 1'b1, 1, 32'h0, 4'b0000, 0);

    // Master abort of a slave 3 read after one cycle.
    @(negedge clock);
    address = 30'h08000000;
    read    = 1'b1;
    @(negedge clock);
    chk("abort cs", {60'b0, slave_cs}, 64'b1000);
    read = 1'b0;
    repeat (4) @(negedge clock);
    chk("abort busy", {63'b0, busy}, 64'd0);
    chk("abort cs cleared", {60'b0, slave_cs}, 64'd0);

    slave_data_in[31:0] = 32'h12345678;
    xfer("read s0 after abort", 30'h00000004, 1'b1, 1'b0, 1'b0, 2, 32'h12345678, 4'b0001, 1);

    repeat (4) @(negedge clock);
    chk("scoreboard drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/bus_decoder.md
Name: bus_decoder

Overview:
- Parametrised address decoder and bus controller between the maxicore32 master bus and up to SLAVES peripherals (memory, led, future devices).
- Replaces the fixed combinational address[31:24] case decode.
- Adds per-region base matching, programmable wait states, slave ready handshake, a timeout watchdog, registered read-data muxing and bus-error reporting with a captured fault address.

Parameters:
- SLAVES, 4, number of slave channels (1..8).
- REGION_BASES, {8'h20,8'h10,8'h0f,8'h00}, packed SLAVES*8; slice i is the address[31:24] value selecting slave i.
- WAIT_STATES, {4'd3,4'd2,4'd0,4'd0}, packed SLAVES*4; minimum wait cycles for slave i.
- TIMEOUT, 16, max cycles in ACCESS before a bus error; must exceed the largest WAIT_STATES entry.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- address  in  30  master word address [31:2].
- read  in  1  master read request, held until ready or bus_error.
- write  in  1  master write request, held until ready or bus_error.
- slave_ready  in  SLAVES  per-slave completion handshake.
- slave_data_in  in  SLAVES*32  packed per-slave read data.
- slave_cs  out  SLAVES  registered one-hot chip selects.
- slave_read  out  1  read gated by any cs.
- slave_write  out  1  write gated by any cs.
- data_out  out  32  registered read data to master.
- ready  out  1  one-cycle transfer-complete pulse.
- bus_error  out  1  one-cycle error pulse.
- error_address  out  30  address of the last faulting access.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (async, immediate):
  - state IDLE; all outputs 0, including data_out and error_address.
  - cs drops mid-access; no ready or bus_error is issued for the aborted transfer.
- States: IDLE, ACCESS, DONE, ERROR.
- IDLE, on the clock edge with read or write high:
  - read and write both high -> ERROR (protocol violation).
  - No REGION_BASES match on address[31:24] -> ERROR.
  - Otherwise -> ACCESS.
    - slave_cs[i] = 1, where i is the lowest matching index; duplicate bases resolve to the lowest index.
    - wait counter = WAIT_STATES[i]; timeout counter = 0.
- ACCESS, each edge, evaluated in this order:
  - read and write both low (master abort) -> IDLE, cs cleared, no pulse.
  - timeout counter == TIMEOUT-1 and not completing this edge -> ERROR.
  - wait counter != 0 -> decrement.
  - wait counter == 0 and slave_ready[i] -> DONE.
    - data_out <= slave_data_in[i] on reads; data_out is held unchanged on writes.
    - cs cleared.
  - Timeout counter increments on every ACCESS edge, wait cycles included.
- DONE: ready = 1 for exactly one cycle; read/write ignored; next edge -> IDLE. The master must drop its request before that edge.
- ERROR:
  - bus_error = 1 for one cycle.
  - error_address latched on entry to ERROR.
  - Next edge -> IDLE.
- slave_read / slave_write = read / write AND (|slave_cs), combinational.
- data_out holds its value between transfers.
- Latency with W wait states and slave_ready tied high:
  - request sampled at edge E0;
  - cs high from E0 through E(W+1);
  - ready high in the cycle after E(W+1).
- Counter widths: $clog2(TIMEOUT+1); the wait counter is 4 bits.
- The master must hold address stable while busy; address is sampled only in IDLE.

Test Plan:
- Reset mid-ACCESS: slave 3 read with 2 waits elapsed, pulse reset -> slave_cs=0, busy=0 immediately, no ready/bus_error afterwards.
- Read 0x00000010 (slave 0, W=0), slave_ready=1, slave_data_in[0]=32'hdeadbeef -> slave_cs=4'b0001 for 1 cycle, ready pulse 2 cycles after request, data_out=32'hdeadbeef.
- Write 0x10000004 (slave 2, W=2), slave_ready=1 -> cs high 3 cycles, ready 4 cycles after request, data_out unchanged, slave_write high only while cs.
- Read 0x0f000000 (slave 1) with slave_ready held low -> after 16 ACCESS cycles bus_error pulse, error_address=30'h03c00000, cs cleared, then IDLE.
- Read 0x40000000 (unmapped) -> bus_error on the next cycle, error_address=30'h10000000, no cs asserted. Then read and write high together at 0x00000000 -> bus_error, no cs.
- Slave 3 read (W=3) with the request dropped after 1 cycle -> IDLE, no ready, no bus_error. A following read to slave 0 completes normally.
